lcd_char_ctrl: RTL

- Parametrised HD44780-compatible character-LCD controller. Successor to the fixed 2x16, 8-bit, hard-coded-text score display driver.
- Holds a ROWS x COLS character buffer that the game logic writes through a simple write port.
- Runs the power-up and init sequence once, then refreshes the panel continuously.
- Supports 8-bit or 4-bit bus mode, 1/2/4 rows and 8–40 columns; reports init and frame status.

---
 rtl/lcd_char_ctrl.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_char_ctrl.sv
// HD44780-compatible character-LCD controller: power-up wait, init command ROM,
// then continuous refresh of a ROWS x COLS character buffer in 8- or 4-bit bus mode.
module lcd_char_ctrl #(
  parameter int         ROWS      = 2,
  parameter int         COLS      = 16,
  parameter int         BUS4      = 0,
  parameter int         PWRUP_CYC = 1_000_000,
  parameter int         SLOT_CYC  = 100_000,
  parameter logic [7:0] INIT_CHAR = 8'h20,
  localparam int        AW        = $clog2(ROWS * COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          lcd_en,
  output logic          lcd_rw,
  output logic          lcd_rs,
  output logic [7:0]    lcd_data,
  output logic          init_done,
  output logic          frame_done
);

  // state   | meaning
  // S_PWRUP | power-up wait, bus idle
  // S_INIT  | replaying the init command ROM
  // S_ADDR  | sending the DDRAM address command for the current row
  // S_CHAR  | sending the buffer byte for the current row/col
  localparam logic [1:0] S_PWRUP = 2'd0;
  localparam logic [1:0] S_INIT  = 2'd1;
  localparam logic [1:0] S_ADDR  = 2'd2;
  localparam logic [1:0] S_CHAR  = 2'd3;

  localparam int NCELL = ROWS * COLS;
  localparam int TW    = $clog2(SLOT_CYC);
  localparam int PW    = $clog2(PWRUP_CYC + 1);
  localparam bit B4    = (BUS4 != 0);
  localparam int NINIT = B4 ? 9 : 5;

  localparam logic [TW-1:0] T_LAST   = TW'(SLOT_CYC - 1);
  localparam logic [TW-1:0] T_EN_HI  = TW'(SLOT_CYC - 2);
  localparam logic [TW-1:0] T_EN_LO  = TW'(SLOT_CYC / 2 - 1);
  localparam logic [PW-1:0] PW_LOAD  = PW'(PWRUP_CYC - 1);
  localparam logic [3:0]    IDX_LAST = 4'(NINIT - 1);
  localparam logic [1:0]    R_LAST   = 2'(ROWS - 1);
  localparam logic [5:0]    C_LAST   = 6'(COLS - 1);
  localparam logic [AW:0]   NCELL_W  = (AW + 1)'(NCELL);

  if (!(ROWS == 1 || ROWS == 2 || ROWS == 4)) begin : g_bad_rows
    $error("lcd_char_ctrl: ROWS must be 1, 2 or 4");
  end
  if (COLS < 8 || COLS > 40) begin : g_bad_cols
    $error("lcd_char_ctrl: COLS must be 8..40");
  end
  if (SLOT_CYC < 4 || (SLOT_CYC % 2) != 0) begin : g_bad_slot
    $error("lcd_char_ctrl: SLOT_CYC must be even and >= 4");
  end

  logic [1:0]    state, st_n;
  logic [PW-1:0] pw_tmr;
  logic [TW-1:0] slot_tmr, tmr_n;
  logic [3:0]    init_idx, idx_n;
  logic [1:0]    row, row_n;
  logic [5:0]    col, col_n;
  logic          nib, nib_n;
  logic [7:0]    cur_byte, byte_n;
  logic [AW-1:0] rd_addr;
  logic          slot_end, step, en_n, fd_n, single;
  logic [7:0]    buf_mem [NCELL];

  // In 4-bit mode the first four init entries are lone high-nibble slots.
  function automatic logic [7:0] init_cmd(input logic [3:0] i);
    logic [7:0] c;
    c = 8'h0C;
    if (B4) begin
      case (i)
        4'd0, 4'd1, 4'd2: c = 8'h30;
        4'd3:             c = 8'h20;
        4'd4:             c = 8'h28;
        4'd5:             c = 8'h08;
        4'd6:             c = 8'h01;
        4'd7:             c = 8'h06;
        default:          c = 8'h0C;
      endcase
    end else begin
      case (i)
        4'd0:    c = 8'h38;
        4'd1:    c = 8'h08;
        4'd2:    c = 8'h01;
        4'd3:    c = 8'h06;
        default: c = 8'h0C;
      endcase
    end
    return c;
  endfunction

  function automatic logic [7:0] row_base(input logic [1:0] r);
    logic [7:0] b;
    case (r)
      2'd0:    b = 8'h00;
      2'd1:    b = 8'h40;
      2'd2:    b = 8'(COLS);
      default: b = 8'(64 + COLS);
    endcase
    return b;
  endfunction

  assign single = B4 && (init_idx < 4'd4);

  always_comb begin
    slot_end = (state != S_PWRUP) && (slot_tmr == '0);
    step     = slot_end || ((state == S_PWRUP) && (pw_tmr == '0));
    st_n     = state;
    idx_n    = init_idx;
    row_n    = row;
    col_n    = col;
    nib_n    = nib;
    if (step) begin
      case (state)
        S_PWRUP: begin
          st_n  = S_INIT;
          idx_n = 4'd0;
          nib_n = 1'b0;
        end
        S_INIT: begin
          if (B4 && !nib && !single) begin
            nib_n = 1'b1;
          end else begin
            nib_n = 1'b0;
            if (init_idx == IDX_LAST) begin
              st_n  = S_ADDR;
              row_n = 2'd0;
            end else begin
              idx_n = init_idx + 4'd1;
            end
          end
        end
        S_ADDR: begin
          if (B4 && !nib) begin
            nib_n = 1'b1;
          end else begin
            nib_n = 1'b0;
            st_n  = S_CHAR;
            col_n = 6'd0;
          end
        end
        default: begin
          if (B4 && !nib) begin
            nib_n = 1'b1;
          end else begin
            nib_n = 1'b0;
            if (col == C_LAST) begin
              st_n  = S_ADDR;
              col_n = 6'd0;
              row_n = (row == R_LAST) ? 2'd0 : row + 2'd1;
            end else begin
              col_n = col + 6'd1;
            end
          end
        end
      endcase
    end
  end

  // The byte for the slot about to start is looked up from the next-state
  // position, so the buffer is sampled on the edge that opens the slot.
  assign rd_addr = AW'(int'(row_n) * COLS + int'(col_n));

  always_comb begin
    byte_n = buf_mem[rd_addr];
    case (st_n)
      S_INIT:  byte_n = init_cmd(idx_n);
      S_ADDR:  byte_n = 8'h80 | row_base(row_n);
      default: ;
    endcase
  end

  // Slot timer counts down SLOT_CYC-1..0; slot position s = SLOT_CYC-1-slot_tmr.
  always_comb begin
    if (state == S_PWRUP) tmr_n = T_LAST;
    else if (slot_end)    tmr_n = T_LAST;
    else                  tmr_n = slot_tmr - 1'b1;
    en_n = (st_n != S_PWRUP) && (tmr_n <= T_EN_HI) && (tmr_n >= T_EN_LO);
    fd_n = (st_n == S_CHAR) && (tmr_n == '0) && (row_n == R_LAST) &&
           (col_n == C_LAST) && (!B4 || nib_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_PWRUP;
      pw_tmr     <= PW_LOAD;
      slot_tmr   <= T_LAST;
      init_idx   <= 4'd0;
      row        <= 2'd0;
      col        <= 6'd0;
      nib        <= 1'b0;
      cur_byte   <= 8'h00;
      lcd_en     <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= st_n;
      init_idx   <= idx_n;
      row        <= row_n;
      col        <= col_n;
      nib        <= nib_n;
      slot_tmr   <= tmr_n;
      lcd_en     <= en_n;
      frame_done <= fd_n;
      if ((state == S_PWRUP) && (pw_tmr != '0)) pw_tmr <= pw_tmr - 1'b1;
      if (step) begin
        lcd_rs <= (st_n == S_CHAR);
        if (!nib_n) begin
          cur_byte <= byte_n;
          lcd_data <= B4 ? {byte_n[7:4], 4'h0} : byte_n;
        end else begin
          lcd_data <= {cur_byte[3:0], 4'h0};
        end
        if ((state == S_INIT) && (st_n == S_ADDR)) init_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCELL; i++) buf_mem[i] <= INIT_CHAR;
    end else if (wr_en && ({1'b0, wr_addr} < NCELL_W)) begin
      buf_mem[wr_addr] <= wr_data;
    end
  end

  assign lcd_rw = 1'b0;

endmodule
